// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE/EXEC/DONE FSM.
// A grant latches the winner's operands, EXEC spans the grant cycle plus one
// compute cycle, and DONE holds the result until it is acknowledged.
module alu_arbiter #(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           req0,
    input  logic           req1,
    input  logic [N-1:0]   A0,
    input  logic [N-1:0]   B0,
    input  logic [N-1:0]   A1,
    input  logic [N-1:0]   B1,
    input  logic [1:0]     Function0,
    input  logic [1:0]     Function1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           busy,
    output logic           result_valid,
    output logic [2*N-1:0] result,
    output logic           result_owner,
    input  logic           result_ack,
    output logic [7:0]     op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   fn;
        logic         owner;
    } op_t;

    state_t         state, state_nxt;
    op_t            op_q, op_sel;
    logic           prio;       // requester favoured when both ask at once
    logic           take;       // a grant happens at this edge
    logic           win;        // index of the requester being granted
    logic           exec_go;    // second EXEC cycle: the latched op is computed
    logic           ack_go;     // result consumed at this edge
    logic [2*N-1:0] alu_out;

    // Arbitration: only sampled in IDLE; tie broken by the priority pointer
    always_comb begin
        take   = (state == IDLE) && (req0 || req1);
        win    = (req0 && req1) ? prio : req1;
        op_sel = win ? '{a: A1, b: B1, fn: Function1, owner: 1'b1}
                     : '{a: A0, b: B0, fn: Function0, owner: 1'b0};
    end

    // The first EXEC cycle is the grant-pulse cycle; compute happens in the next
    assign exec_go = (state == EXEC) && !gnt0 && !gnt1;
    assign ack_go  = (state == DONE) && result_ack;
    assign busy    = (state != IDLE);

    // Shared ALU on the latched operands only, so input changes after the
    // grant cannot disturb the in-flight result
    always_comb begin
        alu_out = '0;
        case (op_q.fn)
            2'b00: alu_out = {{N{1'b0}}, op_q.a} + {{N{1'b0}}, op_q.b};
            2'b01: alu_out = {{(2*N-1){1'b0}}, |{op_q.a, op_q.b}};
            2'b10: alu_out = {{(2*N-1){1'b0}}, &{op_q.a, op_q.b}};
            2'b11: alu_out = {op_q.a, op_q.b};
            default: alu_out = '0;
        endcase
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: acks outside DONE and requests outside IDLE are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take)    state_nxt = EXEC;
            EXEC:    if (exec_go) state_nxt = DONE;
            DONE:    if (ack_go)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant pulses, operand latch, result register, counter and pointer
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            op_q         <= '0;
            result       <= '0;
            result_owner <= 1'b0;
            result_valid <= 1'b0;
            op_count     <= '0;
            prio         <= 1'b0;
        end else begin
            gnt0 <= take && !win;
            gnt1 <= take && win;
            if (take) op_q <= op_sel;
            if (exec_go) begin
                result       <= alu_out;
                result_owner <= op_q.owner;
                result_valid <= 1'b1;
            end
            if (ack_go) begin
                result_valid <= 1'b0;
                op_count     <= op_count + 8'd1;
                prio         <= ~result_owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random traffic, checked against a
// transaction-timeline model (grant edge, result edge, ack edge) in the bench.
module tb_alu_arbiter;

    localparam int N = 4;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           req0, req1, result_ack;
    logic [N-1:0]   A0, B0, A1, B1;
    logic [1:0]     Function0, Function1;
    logic           gnt0, gnt1, busy, result_valid, result_owner;
    logic [2*N-1:0] result;
    logic [7:0]     op_count;

    always #5 Clock = ~Clock;

    alu_arbiter #(.N(N)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0(req0), .req1(req1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Function0(Function0), .Function1(Function1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .result_valid(result_valid), .result(result),
        .result_owner(result_owner), .result_ack(result_ack),
        .op_count(op_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the block is either free, or holds one transaction
    // granted at edge m_gnt_edge whose result shows two edges later and which
    // can be acknowledged from the edge after that.
    bit         m_idle;
    bit         m_prio;
    bit         m_owner;
    bit         m_exp_g0, m_exp_g1;
    logic [7:0] m_res;
    int         m_count;
    int         m_edge;
    int         m_gnt_edge;

    function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] f);
        int cat;
        cat = a * 16 + b;
        case (f)
            2'd0:    return 8'(int'(a) + int'(b));
            2'd1:    return (cat != 0)   ? 8'd1 : 8'd0;
            2'd2:    return (cat == 255) ? 8'd1 : 8'd0;
            default: return 8'(cat);
        endcase
    endfunction

    task automatic model_reset();
        m_idle = 1; m_prio = 0; m_owner = 0; m_count = 0;
        m_edge = 0; m_gnt_edge = -100; m_res = 8'h00;
    endtask

    // Apply inputs for the next edge, advance the model, clock, and check
    task automatic step(input bit r0, input bit r1,
                        input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] f0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] f1,
                        input bit ack);
        bit w;
        bit exp_v;
        req0 = r0; req1 = r1; A0 = a0; B0 = b0; Function0 = f0;
        A1 = a1; B1 = b1; Function1 = f1; result_ack = ack;
        m_edge++;
        m_exp_g0 = 0; m_exp_g1 = 0;
        if (m_idle) begin
            if (r0 || r1) begin
                w = (r0 && r1) ? m_prio : r1;
                m_owner = w;
                m_res = w ? ref_alu(a1, b1, f1) : ref_alu(a0, b0, f0);
                m_gnt_edge = m_edge;
                m_idle = 0;
                if (w) m_exp_g1 = 1; else m_exp_g0 = 1;
            end
        end else if (ack && m_edge >= m_gnt_edge + 3) begin
            m_idle = 1;
            m_count = (m_count + 1) % 256;
            m_prio = !m_owner;
        end
        @(posedge Clock);
        @(negedge Clock);
        exp_v = !m_idle && (m_edge >= m_gnt_edge + 2);
        chk("gnt0", 32'(gnt0), 32'(m_exp_g0));
        chk("gnt1", 32'(gnt1), 32'(m_exp_g1));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("result_valid", 32'(result_valid), 32'(exp_v));
        if (exp_v) begin
            chk("result", 32'(result), 32'(m_res));
            chk("result_owner", 32'(result_owner), 32'(m_owner));
        end
        chk("op_count", 32'(op_count), 32'(m_count));
    endtask

    task automatic idle_step(input bit ack);
        step(0, 0, 4'($urandom), 4'($urandom), 2'($urandom),
             4'($urandom), 4'($urandom), 2'($urandom), ack);
    endtask

    // Assert reset between edges and check outputs before any edge arrives
    task automatic do_reset();
        #2 Reset = 1'b1;
        #1;
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_owner", 32'(result_owner), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_op_count", 32'(op_count), 0);
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
    endtask

    // One single-requester operation; operands scrambled and ack pulsed
    // during EXEC, which must not disturb the result
    task automatic op_single(input bit who, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] f, input logic [7:0] want, input string tag);
        if (who) step(0, 1, 4'($urandom), 4'($urandom), 2'($urandom), a, b, f, 0);
        else     step(1, 0, a, b, f, 4'($urandom), 4'($urandom), 2'($urandom), 0);
        idle_step(1);
        idle_step(0);
        chk(tag, 32'(result), 32'(want));
        chk({tag, "_valid"}, 32'(result_valid), 1);
        idle_step(0);
        chk({tag, "_hold"}, 32'(result), 32'(want));
        idle_step(1);
    endtask

    initial begin
        int ngr, prev, e;
        Reset = 1'b1; req0 = 0; req1 = 0; result_ack = 0;
        A0 = 0; B0 = 0; A1 = 0; B1 = 0; Function0 = 0; Function1 = 0;
        model_reset();
        @(negedge Clock); @(negedge Clock);
        Reset = 1'b0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(op_count), 0);

        // Single request, exact sum
        op_single(0, 4'hF, 4'h3, 2'b00, 8'h12, "sum_F_3");
        chk("count_after_one", 32'(op_count), 1);

        // Tie after reset: requester 0 first, requester 1 held until granted
        do_reset();
        step(1, 1, 4'h5, 4'hA, 2'b11, 4'hF, 4'hF, 2'b10, 0);
        chk("tie_first_gnt0", 32'(gnt0), 1);
        step(0, 1, 0, 0, 0, 4'hF, 4'hF, 2'b10, 0);
        step(0, 1, 0, 0, 0, 4'hF, 4'hF, 2'b10, 0);
        chk("tie_res0", 32'(result), 32'h5A);
        chk("tie_own0", 32'(result_owner), 0);
        step(0, 1, 0, 0, 0, 4'hF, 4'hF, 2'b10, 1);
        step(0, 1, 0, 0, 0, 4'hF, 4'hF, 2'b10, 0);
        chk("tie_second_gnt1", 32'(gnt1), 1);
        idle_step(0);
        idle_step(0);
        chk("tie_res1", 32'(result), 32'h01);
        chk("tie_own1", 32'(result_owner), 1);
        idle_step(1);

        // Reduction corner cases
        op_single(1, 4'h0, 4'h0, 2'b01, 8'h00, "or_zero");
        op_single(0, 4'hF, 4'hE, 2'b10, 8'h00, "and_FE");
        op_single(1, 4'hF, 4'hF, 2'b10, 8'h01, "and_FF");

        // Both held, ack held: strict alternation, grants 4 cycles apart
        do_reset();
        ngr = 0; prev = 0; e = 0;
        while (ngr < 8 && e < 40) begin
            step(1, 1, 4'($urandom), 4'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom), 2'($urandom), 1);
            e++;
            if (gnt0 || gnt1) begin
                chk("alt_owner", 32'(gnt1), 32'(ngr % 2));
                if (ngr > 0) chk("gnt_spacing", 32'(e - prev), 4);
                prev = e;
                ngr++;
            end
        end
        chk("alt_grants", 32'(ngr), 8);

        // Reset in the middle of an operation; no ack needed afterwards
        step(1, 0, 4'h3, 4'h4, 2'b00, 0, 0, 0, 0);
        idle_step(0);
        do_reset();
        op_single(1, 4'h9, 4'h9, 2'b00, 8'h12, "post_reset_op");

        // 256 completed operations wrap the counter
        do_reset();
        for (int i = 0; i < 1024; i++)
            step(1, 0, 4'($urandom), 4'($urandom), 2'($urandom), 0, 0, 0, 1);
        chk("count_wrap", 32'(op_count), 0);

        // Random traffic with one reset in the middle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(($urandom % 3) == 0, ($urandom % 3) == 0,
                 4'($urandom), 4'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom), 2'($urandom), ($urandom % 2) == 0);
            if (gnt0 && gnt1) chk("gnt_exclusive", 32'(gnt0 & gnt1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: Parameter N, default 4, operand width in bits; the result width SHALL be 2N.
REQ-002: Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003: Reset  input  1  asynchronous, active-high reset.
REQ-004: req0, req1  input  1 each  operation request from requester 0 / requester 1.
REQ-005: A0, B0, A1, B1  input  N each  operands of requester 0 / requester 1.
REQ-006: Function0, Function1  input  2 each  opcode of requester 0 / requester 1.
REQ-007: gnt0, gnt1  output  1 each  one-cycle grant pulse to the accepted requester.
REQ-008: busy  output  1  high whenever state is not IDLE.
REQ-009: result_valid  output  1  result available.
REQ-010: result  output  2N  registered ALU result.
REQ-011: result_owner  output  1  index of the requester that owns the result.
REQ-012: result_ack  input  1  result consumed.
REQ-013: op_count  output  8  count of completed operations.

Function
REQ-014: The opcode map SHALL be as follows.
- 00: {N'b0, A} + {N'b0, B}, exact sum with no overflow.
- 01: OR-reduction of {A, B}, zero-extended to 2N.
- 10: AND-reduction of {A, B}, zero-extended to 2N.
- 11: concatenation {A, B}, with A in the MSBs.
REQ-015: The block SHALL contain one shared ALU, one FSM with states IDLE, EXEC and DONE, a 1-bit priority pointer, and operand/opcode/owner latches.
REQ-016: In IDLE, at an edge where req0 or req1 is high, the block SHALL perform the following in one action.
- Select the winner.
- Latch the winner's A, B, Function and index.
- Pulse the winner's gnt high for exactly the following cycle.
- Move to EXEC.
REQ-017: Winner selection SHALL follow these rules.
- One requester high: that requester wins.
- Both high: the requester named by the priority pointer wins.
REQ-018: In EXEC, for exactly one cycle, the block SHALL compute the ALU on the latched values, register the result into result/result_owner, set result_valid, and move to DONE.
REQ-019: In DONE, result_valid, result and result_owner SHALL hold stable until result_ack is sampled high.
REQ-020: On that ack edge, the block SHALL perform the following.
- Clear result_valid.
- Increment op_count modulo 256 (255 -> 0).
- Set the priority pointer to the requester that was not served.
- Return to IDLE.
REQ-021: result_ack sampled in IDLE or EXEC SHALL be ignored.
REQ-022: req0/req1 sampled in EXEC or DONE SHALL be ignored; a request still high on return to IDLE SHALL be treated as a new request.
REQ-023: Requester inputs changing after the grant edge SHALL NOT affect the in-flight result.
REQ-024: Latency from the request-sampling edge k SHALL be:
- gnt high in cycle k..k+1;
- result_valid high from edge k+2.
REQ-025: Minimum spacing between grants SHALL be 4 cycles, reached when result_ack is held high.
REQ-026: gnt0 and gnt1 SHALL never be high together.
REQ-027: A grant SHALL never be issued while busy is high.
REQ-028: With both requests held high continuously, service SHALL alternate strictly between the requesters.

Reset
REQ-029: While Reset is high, the block SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- gnt0, gnt1, busy, result_valid and result_owner to 0;
- result to 0;
- op_count to 0;
- the priority pointer to requester 0.
REQ-030: Reset asserted in EXEC or DONE SHALL discard the in-flight operation, and no ack SHALL be required afterward.
REQ-031: After Reset deasserts, the first rising edge SHALL be treated as IDLE sampling.

Verification
REQ-032: Reset pulse during activity -> all outputs 0 within the reset cycle, with no clock edge needed.
REQ-033: N=4, req0 only, A0=F, B0=3, Function0=00 -> gnt0 one cycle; 2 edges later result=8'h12, owner=0; ack -> op_count=1.
REQ-034: Simultaneous req0 (A0=5, B0=A, Function0=11) and req1 (A1=F, B1=F, Function1=10) after reset, then both deasserted after their grants -> results in this order:
- first: result=8'h5A, owner=0;
- second: result=8'h01, owner=1.
REQ-035: Both requests held high with ack held high for 8 operations -> owners 0,1,0,1,0,1,0,1 and grants exactly 4 cycles apart.
REQ-036: Function=01 with A=0, B=0 -> result=8'h00; Function=10 with A=F, B=E -> result=8'h00.
REQ-037: Operands changed during EXEC -> result unchanged; result_ack pulsed during EXEC -> ignored, result_valid still rises and holds.
REQ-038: 256 completed operations -> op_count wraps to 0.
